ttt_turn_sequencer: RTL and testbench

Turn sequencer and referee for the tic-tac-toe game datapath. Owns the 3x3 board register, alternates turns between a human (hMove plus enter_L button) and a pluggable computer-move engine over a req/ack handshake, and rejects illegal moves. Detects win and draw, and restarts on newGame_L. Sits between the board I/O (switches, buttons, hex displays) and any move-engine module.

---
 rtl/ttt_pkg.sv | 43 ++++
 rtl/ttt_line_check.sv | 20 ++
 rtl/ttt_turn_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ttt_turn_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types, the eight winning lines and board cell accessors for the
// tic-tac-toe turn sequencer.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    COMP  = 2'b01,
    HUMAN = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    C_REQ,
    C_WAIT,
    H_WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] LINES [8][3] = '{
    '{4'd1, 4'd2, 4'd3}, '{4'd4, 4'd5, 4'd6}, '{4'd7, 4'd8, 4'd9},
    '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8}, '{4'd3, 4'd6, 4'd9},
    '{4'd1, 4'd5, 4'd9}, '{4'd3, 4'd5, 4'd7}
  };

  // Cells are numbered 1..9; anything outside that range reads as EMPTY.
  function automatic cell_t get_cell(input logic [17:0] b, input logic [3:0] k);
    logic [4:0] lo;
    lo = {k - 4'd1, 1'b0};
    if (k == 4'd0 || k > 4'd9) return EMPTY;
    return cell_t'(b[lo +: 2]);
  endfunction

  function automatic logic [17:0] put_cell(input logic [17:0] b, input logic [3:0] k,
                                           input cell_t v);
    logic [17:0] r;
    logic [4:0]  lo;
    r  = b;
    lo = {k - 4'd1, 1'b0};
    if (k != 4'd0 && k <= 4'd9) r[lo +: 2] = v;
    return r;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for one player over the packed board.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  cell_t       player,
  output logic        hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (get_cell(board, LINES[i][0]) == player &&
          get_cell(board, LINES[i][1]) == player &&
          get_cell(board, LINES[i][2]) == player)
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe referee: owns the board, alternates computer (req/ack engine)
// and human (enter button) turns, rejects illegal moves, flags win/draw/fault.
module ttt_turn_sequencer
  import ttt_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  hMove,
  input  logic        enter_L,
  input  logic        newGame_L,
  input  logic        engAck,
  input  logic [3:0]  engMove,
  output logic        engReq,
  output logic [17:0] board,
  output logic [3:0]  cMove,
  output logic [3:0]  moveCount,
  output logic        humanTurn,
  output logic        illegal,
  output logic        win,
  output logic        hWin,
  output logic        draw,
  output logic        fault
);

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  cmove_q, cmove_d;
  logic [3:0]  count_q, count_d;
  logic        illegal_q, illegal_d;
  logic        win_q, win_d;
  logic        hwin_q, hwin_d;
  logic        draw_q, draw_d;
  logic        fault_q, fault_d;
  logic        mover_human_q, mover_human_d;
  logic        enter_q, new_game_q;

  logic        enter_press, new_game_press;
  logic        eng_legal, h_legal, line_hit;
  cell_t       check_player;

  assign enter_press    = enter_q & ~enter_L;
  assign new_game_press = new_game_q & ~newGame_L;
  assign eng_legal = (engMove != 4'd0) && (engMove <= 4'd9) && (get_cell(board_q, engMove) == EMPTY);
  assign h_legal   = (hMove != 4'd0) && (hMove <= 4'd9) && (get_cell(board_q, hMove) == EMPTY);

  // Only the player who just moved can have completed a line.
  assign check_player = mover_human_q ? HUMAN : COMP;

  ttt_line_check u_line_check (
    .board  (board_q),
    .player (check_player),
    .hit    (line_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= C_REQ;
      board_q       <= '0;
      cmove_q       <= '0;
      count_q       <= '0;
      illegal_q     <= 1'b0;
      win_q         <= 1'b0;
      hwin_q        <= 1'b0;
      draw_q        <= 1'b0;
      fault_q       <= 1'b0;
      mover_human_q <= 1'b0;
      enter_q       <= 1'b1;
      new_game_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      cmove_q       <= cmove_d;
      count_q       <= count_d;
      illegal_q     <= illegal_d;
      win_q         <= win_d;
      hwin_q        <= hwin_d;
      draw_q        <= draw_d;
      fault_q       <= fault_d;
      mover_human_q <= mover_human_d;
      enter_q       <= enter_L;
      new_game_q    <= newGame_L;
    end
  end

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    cmove_d       = cmove_q;
    count_d       = count_q;
    illegal_d     = illegal_q;
    win_d         = win_q;
    hwin_d        = hwin_q;
    draw_d        = draw_q;
    fault_d       = fault_q;
    mover_human_d = mover_human_q;

    if (new_game_press) begin
      state_d       = C_REQ;
      board_d       = '0;
      cmove_d       = '0;
      count_d       = '0;
      illegal_d     = 1'b0;
      win_d         = 1'b0;
      hwin_d        = 1'b0;
      draw_d        = 1'b0;
      fault_d       = 1'b0;
      mover_human_d = 1'b0;
    end else begin
      case (state_q)
        C_REQ:  state_d = C_WAIT;
        C_WAIT: begin
          if (engAck) begin
            if (eng_legal) begin
              board_d       = put_cell(board_q, engMove, COMP);
              cmove_d       = engMove;
              count_d       = count_q + 4'd1;
              mover_human_d = 1'b0;
              state_d       = CHECK;
            end else begin
              fault_d = 1'b1;
              state_d = DONE;
            end
          end
        end
        H_WAIT: begin
          if (enter_press) begin
            if (h_legal) begin
              board_d       = put_cell(board_q, hMove, HUMAN);
              illegal_d     = 1'b0;
              count_d       = count_q + 4'd1;
              mover_human_d = 1'b1;
              state_d       = CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_hit) begin
            if (mover_human_q) hwin_d = 1'b1;
            else               win_d  = 1'b1;
            state_d = DONE;
          end else if (count_q == 4'd9) begin
            draw_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = mover_human_q ? C_REQ : H_WAIT;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = C_REQ;
      endcase
    end
  end

  assign engReq    = (state_q == C_REQ) || (state_q == C_WAIT);
  assign humanTurn = (state_q == H_WAIT);
  assign board     = board_q;
  assign cMove     = cmove_q;
  assign moveCount = count_q;
  assign illegal   = illegal_q;
  assign win       = win_q;
  assign hWin      = hwin_q;
  assign draw      = draw_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Self-checking bench for ttt_turn_sequencer: directed scenarios plus random
// games compared against a cell-array model of the game rules.
module tb_ttt_turn_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  hMove = '0;
  logic        enter_L = 1'b1;
  logic        newGame_L = 1'b1;
  logic        engAck = 1'b0;
  logic [3:0]  engMove = '0;
  logic        engReq;
  logic [17:0] board;
  logic [3:0]  cMove;
  logic [3:0]  moveCount;
  logic        humanTurn, illegal, win, hWin, draw, fault;

  int checks = 0;
  int errors = 0;

  // Model: mb[k] is 0 empty, 1 computer, 2 human for cells 1..9.
  int mb [10];
  int mcount;
  int mcmove;
  int LN [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                    '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  always #5 clock = ~clock;

  ttt_turn_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .hMove     (hMove),
    .enter_L   (enter_L),
    .newGame_L (newGame_L),
    .engAck    (engAck),
    .engMove   (engMove),
    .engReq    (engReq),
    .board     (board),
    .cMove     (cMove),
    .moveCount (moveCount),
    .humanTurn (humanTurn),
    .illegal   (illegal),
    .win       (win),
    .hWin      (hWin),
    .draw      (draw),
    .fault     (fault)
  );

  function automatic void m_clear();
    for (int k = 0; k < 10; k++) mb[k] = 0;
    mcount = 0;
    mcmove = 0;
  endfunction

  function automatic logic [17:0] m_vec();
    logic [17:0] v;
    v = '0;
    for (int k = 1; k <= 9; k++) v = v | (18'(mb[k]) << (2 * (k - 1)));
    return v;
  endfunction

  function automatic bit m_line(input int p);
    for (int l = 0; l < 8; l++)
      if (mb[LN[l][0]] == p && mb[LN[l][1]] == p && mb[LN[l][2]] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_legal(input int c);
    if (c < 1 || c > 9) return 1'b0;
    return mb[c] == 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; engAck = 1'b0; enter_L = 1'b1; newGame_L = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_clear();
  endtask

  task automatic wait_req();
    int n = 0;
    while (engReq !== 1'b1 && n < 10) begin tick(); n++; end
    if (engReq !== 1'b1) begin
      checks++; errors++;
      $display("FAIL engreq_timeout engReq=%b expected 1", engReq);
    end
  endtask

  // Ack lands one cycle after engReq is seen; returns in the cycle after the ack.
  task automatic comp_ack(input int c);
    wait_req();
    tick();
    engAck = 1'b1; engMove = 4'(c);
    tick();
    engAck = 1'b0;
  endtask

  task automatic human_press(input int c);
    enter_L = 1'b1;
    tick();
    hMove = 4'(c); enter_L = 1'b0;
    tick();
    enter_L = 1'b1;
  endtask

  task automatic play_comp(input int c);
    comp_ack(c);
    mb[c] = 1; mcount++; mcmove = c;
    tick();
  endtask

  task automatic play_human(input int c);
    human_press(c);
    mb[c] = 2; mcount++;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (engReq !== 1'b1 || board !== 18'd0 || moveCount !== 4'd0 || cMove !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs engReq=%b board=%h count=%0d cMove=%0d expected 1/0/0/0",
               engReq, board, moveCount, cMove);
    end
    checks++;
    if ({humanTurn, illegal, win, hWin, draw, fault} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags flags=%b expected 000000", {humanTurn, illegal, win, hWin, draw, fault});
    end
  endtask

  task automatic test_first_move();
    do_reset();
    comp_ack(5);
    checks++;
    if (board !== 18'h00100 || cMove !== 4'd5 || moveCount !== 4'd1 || humanTurn !== 1'b0) begin
      errors++;
      $display("FAIL first_move board=%h cMove=%0d count=%0d ht=%b expected 00100/5/1/0",
               board, cMove, moveCount, humanTurn);
    end
    tick();
    checks++;
    if (humanTurn !== 1'b1) begin
      errors++;
      $display("FAIL first_move_turn humanTurn=%b expected 1", humanTurn);
    end
  endtask

  task automatic test_comp_win();
    do_reset();
    play_comp(5); play_human(6); play_comp(1); play_human(2);
    comp_ack(9);
    mb[9] = 1; mcount++; mcmove = 9;
    checks++;
    if (win !== 1'b0 || board !== m_vec() || moveCount !== 4'd5) begin
      errors++;
      $display("FAIL win_n1 win=%b board=%h count=%0d expected 0/%h/5", win, board, moveCount, m_vec());
    end
    tick();
    checks++;
    if (win !== 1'b1 || hWin !== 1'b0 || humanTurn !== 1'b0 || engReq !== 1'b0) begin
      errors++;
      $display("FAIL win_n2 win=%b hWin=%b ht=%b engReq=%b expected 1/0/0/0", win, hWin, humanTurn, engReq);
    end
    for (int i = 0; i < 3; i++) begin
      human_press(3 + i);
      tick();
      checks++;
      if (board !== m_vec() || win !== 1'b1 || moveCount !== 4'd5 || illegal !== 1'b0) begin
        errors++;
        $display("FAIL done_hold board=%h win=%b count=%0d illegal=%b expected %h/1/5/0",
                 board, win, moveCount, illegal, m_vec());
      end
    end
  endtask

  task automatic test_illegal_presses();
    int bad [3] = '{5, 0, 12};
    do_reset();
    play_comp(5);
    for (int i = 0; i < 3; i++) begin
      human_press(bad[i]);
      checks++;
      if (illegal !== 1'b1 || board !== m_vec() || humanTurn !== 1'b1) begin
        errors++;
        $display("FAIL illegal_press hMove=%0d illegal=%b board=%h ht=%b expected 1/%h/1",
                 bad[i], illegal, board, humanTurn, m_vec());
      end
    end
    human_press(3);
    mb[3] = 2; mcount++;
    checks++;
    if (illegal !== 1'b0 || board !== m_vec() || moveCount !== 4'd2) begin
      errors++;
      $display("FAIL legal_after_illegal illegal=%b board=%h count=%0d expected 0/%h/2",
               illegal, board, moveCount, m_vec());
    end
  endtask

  task automatic test_draw();
    do_reset();
    play_comp(1); play_human(2); play_comp(3); play_human(5); play_comp(4);
    play_human(7); play_comp(8); play_human(6); play_comp(9);
    checks++;
    if (draw !== 1'b1 || moveCount !== 4'd9 || win !== 1'b0 || hWin !== 1'b0 || board !== m_vec()) begin
      errors++;
      $display("FAIL draw draw=%b count=%0d win=%b hWin=%b board=%h expected 1/9/0/0/%h",
               draw, moveCount, win, hWin, board, m_vec());
    end
  endtask

  task automatic test_fault();
    do_reset();
    play_comp(5); play_human(1);
    comp_ack(5);
    checks++;
    if (fault !== 1'b1 || board !== m_vec() || moveCount !== 4'd2 || engReq !== 1'b0) begin
      errors++;
      $display("FAIL fault fault=%b board=%h count=%0d engReq=%b expected 1/%h/2/0",
               fault, board, moveCount, engReq, m_vec());
    end
    tick();
    checks++;
    if (fault !== 1'b1 || humanTurn !== 1'b0 || engReq !== 1'b0) begin
      errors++;
      $display("FAIL fault_hold fault=%b ht=%b engReq=%b expected 1/0/0", fault, humanTurn, engReq);
    end
  endtask

  task automatic test_newgame_vs_ack();
    do_reset();
    play_comp(5); play_human(1);
    wait_req();
    tick();
    engAck = 1'b1; engMove = 4'd9; newGame_L = 1'b0;
    tick();
    engAck = 1'b0; newGame_L = 1'b1;
    m_clear();
    checks++;
    if (board !== 18'd0 || moveCount !== 4'd0 || cMove !== 4'd0 || engReq !== 1'b1) begin
      errors++;
      $display("FAIL newgame_priority board=%h count=%0d cMove=%0d engReq=%b expected 0/0/0/1",
               board, moveCount, cMove, engReq);
    end
    tick();
    checks++;
    if (board !== 18'd0 || engReq !== 1'b1) begin
      errors++;
      $display("FAIL newgame_discard board=%h engReq=%b expected 0/1", board, engReq);
    end
  endtask

  task automatic test_enter_held();
    do_reset();
    play_comp(5);
    hMove = 4'd4; enter_L = 1'b0;
    for (int i = 0; i < 20; i++) begin
      engAck = (i == 4);
      engMove = 4'd1;
      tick();
    end
    engAck = 1'b0; enter_L = 1'b1;
    mb[4] = 2; mb[1] = 1; mcount = 3; mcmove = 1;
    checks++;
    if (moveCount !== 4'd3 || board !== m_vec() || humanTurn !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL enter_held count=%0d board=%h ht=%b illegal=%b expected 3/%h/1/0",
               moveCount, board, humanTurn, illegal, m_vec());
    end
  endtask

  task automatic test_random_games(input int n);
    int c, r;
    bit over, hturn, w, d, legal;
    logic [17:0] prev;
    int empties [$];
    for (int g = 0; g < n; g++) begin
      newGame_L = 1'b0;
      tick();
      newGame_L = 1'b1;
      m_clear();
      checks++;
      if (engReq !== 1'b1 || board !== 18'd0 || moveCount !== 4'd0 || cMove !== 4'd0 ||
          {win, hWin, draw, fault, illegal} !== 5'd0) begin
        errors++;
        $display("FAIL rnd_newgame engReq=%b board=%h count=%0d cMove=%0d flags=%b expected 1/0/0/0/00000",
                 engReq, board, moveCount, cMove, {win, hWin, draw, fault, illegal});
      end
      over = 1'b0; hturn = 1'b0;
      while (!over) begin
        empties.delete();
        for (int k = 1; k <= 9; k++) if (mb[k] == 0) empties.push_back(k);
        c = empties[$urandom_range(0, empties.size() - 1)];
        r = $urandom_range(0, 19);
        if (r == 0) c = 0;
        else if (r == 1) c = $urandom_range(10, 15);
        else if ((r == 2 || (hturn && r < 5)) && mcount > 0)
          for (int k = 1; k <= 9; k++) if (mb[k] != 0) c = k;
        legal = m_legal(c);
        prev = m_vec();
        if (!hturn) begin
          comp_ack(c);
          if (legal) begin
            mb[c] = 1; mcount++; mcmove = c;
            checks++;
            if (board !== m_vec() || cMove !== 4'(mcmove) || moveCount !== 4'(mcount) ||
                engReq !== 1'b0 || humanTurn !== 1'b0) begin
              errors++;
              $display("FAIL rnd_comp_move cell=%0d board=%h cMove=%0d count=%0d expected %h/%0d/%0d",
                       c, board, cMove, moveCount, m_vec(), mcmove, mcount);
            end
            tick();
            w = m_line(1); d = !w && mcount == 9;
            checks++;
            if (win !== w || draw !== d || hWin !== 1'b0 || humanTurn !== !(w || d)) begin
              errors++;
              $display("FAIL rnd_comp_result win=%b draw=%b hWin=%b ht=%b expected %b/%b/0/%b",
                       win, draw, hWin, humanTurn, w, d, !(w || d));
            end
            over = w || d; hturn = 1'b1;
          end else begin
            checks++;
            if (fault !== 1'b1 || board !== prev || engReq !== 1'b0) begin
              errors++;
              $display("FAIL rnd_fault cell=%0d fault=%b board=%h engReq=%b expected 1/%h/0",
                       c, fault, board, engReq, prev);
            end
            over = 1'b1;
          end
        end else begin
          human_press(c);
          if (legal) begin
            mb[c] = 2; mcount++;
            checks++;
            if (board !== m_vec() || illegal !== 1'b0 || moveCount !== 4'(mcount) || cMove !== 4'(mcmove)) begin
              errors++;
              $display("FAIL rnd_human_move cell=%0d board=%h illegal=%b count=%0d expected %h/0/%0d",
                       c, board, illegal, moveCount, m_vec(), mcount);
            end
            tick();
            w = m_line(2); d = !w && mcount == 9;
            checks++;
            if (hWin !== w || draw !== d || win !== 1'b0 || engReq !== !(w || d)) begin
              errors++;
              $display("FAIL rnd_human_result hWin=%b draw=%b win=%b engReq=%b expected %b/%b/0/%b",
                       hWin, draw, win, engReq, w, d, !(w || d));
            end
            over = w || d; hturn = 1'b0;
          end else begin
            checks++;
            if (illegal !== 1'b1 || board !== prev || humanTurn !== 1'b1) begin
              errors++;
              $display("FAIL rnd_reject cell=%0d illegal=%b board=%h ht=%b expected 1/%h/1",
                       c, illegal, board, humanTurn, prev);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_move();
    test_comp_win();
    test_illegal_presses();
    test_draw();
    test_fault();
    test_newgame_vs_ack();
    test_enter_held();
    test_random_games(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
